// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor controller.
package serial_sub_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_sub_if.sv
// Start/done handshake bundle between a requester and serial_sub_ctrl.
interface serial_sub_if
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) ();

   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             done_valid;
   logic             done_ready;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
   logic             busy;

   modport master (
      output start_valid, a, b, done_ready,
      input  start_ready, done_valid, diff, borrow_out, busy
   );

   modport slave (
      input  start_valid, a, b, done_ready,
      output start_ready, done_valid, diff, borrow_out, busy
   );

endinterface

// File: rtl/fs_cell.sv
// Combinational full-subtractor: ai - bi - bin, built from two half-subtractors.
module fs_cell (
   input  logic ai,
   input  logic bi,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic d1_s;
   logic b1_s;
   logic b2_s;

   half_sub u_hs_ab (
      .x  (ai),
      .y  (bi),
      .d  (d1_s),
      .bo (b1_s)
   );

   half_sub u_hs_bin (
      .x  (d1_s),
      .y  (bin),
      .d  (d),
      .bo (b2_s)
   );

   assign bout = b1_s | b2_s;

endmodule

// File: rtl/half_sub.sv
// Combinational half-subtractor: x - y with borrow out.
module half_sub (
   input  logic x,
   input  logic y,
   output logic d,
   output logic bo
);

   assign d  = x ^ y;
   assign bo = ~x & y;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor: one bit per cycle, LSB first, with
// valid/ready handshakes on operand intake and result delivery.
module serial_sub_ctrl
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic        clk,
   input  logic        rst_n,
   serial_sub_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state_r;
   state_t           state_nxt_s;
   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;
   logic [WIDTH-1:0] res_sh_r;
   logic [WIDTH-1:0] res_nxt_s;
   logic [WIDTH-1:0] diff_r;
   logic [CW-1:0]    cnt_r;
   logic             bin_r;
   logic             borrow_r;
   logic             d_s;
   logic             bout_s;
   logic             start_hs_s;
   logic             done_hs_s;
   logic             last_bit_s;

   fs_cell u_fs (
      .ai   (a_sh_r[0]),
      .bi   (b_sh_r[0]),
      .bin  (bin_r),
      .d    (d_s),
      .bout (bout_s)
   );

   assign start_hs_s = bus.start_valid && (state_r == IDLE);
   assign done_hs_s  = bus.done_ready && (state_r == DONE);
   assign last_bit_s = (state_r == RUN) && (cnt_r == CW'(WIDTH - 1));
   // New bit enters at the MSB so bit 0 reaches diff[0] after WIDTH shifts.
   assign res_nxt_s  = (res_sh_r >> 1) | (WIDTH'(d_s) << (WIDTH - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_hs_s) state_nxt_s = RUN;
            else            state_nxt_s = IDLE;
         end
         RUN: begin
            if (last_bit_s) state_nxt_s = DONE;
            else            state_nxt_s = RUN;
         end
         DONE: begin
            if (done_hs_s) state_nxt_s = IDLE;
            else           state_nxt_s = DONE;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Operand shifters, borrow chain, bit counter and result capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh_r   <= '0;
         b_sh_r   <= '0;
         res_sh_r <= '0;
         diff_r   <= '0;
         cnt_r    <= '0;
         bin_r    <= 1'b0;
         borrow_r <= 1'b0;
      end else if (start_hs_s) begin
         a_sh_r <= bus.a;
         b_sh_r <= bus.b;
         bin_r  <= 1'b0;
         cnt_r  <= '0;
      end else if (state_r == RUN) begin
         a_sh_r   <= a_sh_r >> 1;
         b_sh_r   <= b_sh_r >> 1;
         res_sh_r <= res_nxt_s;
         bin_r    <= bout_s;
         cnt_r    <= cnt_r + CW'(1);
         if (last_bit_s) begin
            diff_r   <= res_nxt_s;
            borrow_r <= bout_s;
         end
      end
   end

   assign bus.start_ready = (state_r == IDLE);
   assign bus.done_valid  = (state_r == DONE);
   assign bus.busy        = (state_r != IDLE);
   assign bus.diff        = diff_r;
   assign bus.borrow_out  = borrow_r;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed plus randomized bench for serial_sub_ctrl (WIDTH=8 and WIDTH=1 builds).
module tb_serial_sub_ctrl;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   npass = 0;
   int   ntot  = 0;
   int   nfail = 0;

   always #5 clk = ~clk;

   serial_sub_if #(.WIDTH(W)) bus8 ();
   serial_sub_if #(.WIDTH(1)) bus1 ();

   serial_sub_ctrl #(.WIDTH(W)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
   serial_sub_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

   task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: {borrow, diff} from plain modular arithmetic.
   function automatic logic [8:0] ref_sub(input logic [7:0] x, input logic [7:0] y);
      int unsigned d;
      d = (int'(x) + 256 - int'(y)) % 256;
      return {(x < y), d[7:0]};
   endfunction

   // All tasks start and end 1 time unit after a rising edge.
   task automatic start8(input logic [7:0] av, input logic [7:0] bv);
      int cyc;
      cyc = 0;
      while (bus8.start_ready !== 1'b1 && cyc < 50) begin
         @(posedge clk); #1; cyc++;
      end
      check("start_ready_wait", bus8.start_ready, 33'd1);
      bus8.a = av;
      bus8.b = bv;
      bus8.start_valid = 1'b1;
      @(posedge clk); #1;
      bus8.start_valid = 1'b0;
      check("busy_after_start", bus8.busy, 33'd1);
      check("start_ready_in_run", bus8.start_ready, 33'd0);
   endtask

   task automatic wait_done8(input bit noise);
      int lat;
      lat = 0;
      while (bus8.done_valid !== 1'b1 && lat < 100) begin
         if (noise) begin
            bus8.start_valid = 1'($urandom_range(0, 1));
            bus8.a = 8'($urandom);
            bus8.b = 8'($urandom);
            bus8.done_ready = 1'($urandom_range(0, 1));
         end
         @(posedge clk); #1; lat++;
      end
      if (noise) bus8.start_valid = 1'b0;
      bus8.done_ready = 1'b0;
      check("latency", 33'(lat), 33'(W));
   endtask

   task automatic result8(input string tag, input logic [8:0] exp);
      check({tag, "_diff"}, bus8.diff, 33'(exp[7:0]));
      check({tag, "_borrow"}, bus8.borrow_out, 33'(exp[8]));
      check({tag, "_start_ready"}, bus8.start_ready, 33'd0);
   endtask

   task automatic hold8(input int n, input logic [8:0] exp);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         check("hold_valid", bus8.done_valid, 33'd1);
         check("hold_diff", bus8.diff, 33'(exp[7:0]));
         check("hold_borrow", bus8.borrow_out, 33'(exp[8]));
      end
   endtask

   task automatic consume8(input logic [8:0] exp);
      bus8.done_ready = 1'b1;
      @(posedge clk); #1;
      bus8.done_ready = 1'b0;
      check("consume_valid_drop", bus8.done_valid, 33'd0);
      check("consume_idle_ready", bus8.start_ready, 33'd1);
      check("consume_idle_busy", bus8.busy, 33'd0);
      check("retain_diff", bus8.diff, 33'(exp[7:0]));
      check("retain_borrow", bus8.borrow_out, 33'(exp[8]));
   endtask

   task automatic full_op8(input string tag, input logic [7:0] av, input logic [7:0] bv);
      logic [8:0] e;
      e = ref_sub(av, bv);
      start8(av, bv);
      wait_done8(1'b0);
      result8(tag, e);
      consume8(e);
   endtask

   initial begin
      logic [8:0] e;
      logic [7:0] ra;
      logic [7:0] rb;
      logic       a1;
      logic       b1;
      int         seen;

      bus8.start_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.done_ready = 1'b0;
      bus1.start_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.done_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_start_ready", bus8.start_ready, 33'd1);
      check("rst_done_valid", bus8.done_valid, 33'd0);
      check("rst_busy", bus8.busy, 33'd0);
      check("rst_diff", bus8.diff, 33'd0);
      check("rst_borrow", bus8.borrow_out, 33'd0);
      check("rst1_start_ready", bus1.start_ready, 33'd1);

      // First handshake right after reset release, then 5-cycle hold.
      bus8.a = 8'h05; bus8.b = 8'h03; bus8.start_valid = 1'b1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      bus8.start_valid = 1'b0;
      check("first_start_accepted", bus8.busy, 33'd1);
      wait_done8(1'b0);
      e = ref_sub(8'h05, 8'h03);
      check("basic_diff_const", bus8.diff, 33'h02);
      result8("basic", e);
      hold8(5, e);
      consume8(e);

      full_op8("underflow", 8'h00, 8'h01);
      full_op8("equal", 8'hA5, 8'hA5);

      // start_valid held high with a different operand throughout RUN/DONE.
      e = ref_sub(8'h33, 8'h11);
      start8(8'h33, 8'h11);
      bus8.a = 8'h10; bus8.b = 8'h00; bus8.start_valid = 1'b1;
      wait_done8(1'b0);
      result8("ignored_start", e);
      consume8(e);
      @(posedge clk); #1;
      bus8.start_valid = 1'b0;
      check("second_start_after_idle", bus8.busy, 33'd1);
      wait_done8(1'b0);
      e = ref_sub(8'h10, 8'h00);
      result8("second_op", e);
      consume8(e);

      // Reset in the middle of RUN aborts the operation.
      start8(8'h77, 8'h11);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_done_valid", bus8.done_valid, 33'd0);
      check("abort_diff", bus8.diff, 33'd0);
      check("abort_borrow", bus8.borrow_out, 33'd0);
      check("abort_busy", bus8.busy, 33'd0);
      check("abort_start_ready", bus8.start_ready, 33'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < W + 4; i++) begin
         @(posedge clk); #1;
         if (bus8.done_valid !== 1'b0) seen++;
      end
      check("no_done_after_abort", 33'(seen), 33'd0);
      full_op8("post_reset", 8'h09, 8'h04);

      // WIDTH=1 build: exhaustive over both operand bits.
      for (int i = 0; i < 4; i++) begin
         a1 = 1'(i >> 1);
         b1 = 1'(i);
         bus1.a = a1; bus1.b = b1; bus1.start_valid = 1'b1;
         @(posedge clk); #1;
         bus1.start_valid = 1'b0;
         check("w1_run_no_valid", bus1.done_valid, 33'd0);
         @(posedge clk); #1;
         check("w1_done_valid", bus1.done_valid, 33'd1);
         check("w1_diff", bus1.diff, 33'(a1 ^ b1));
         check("w1_borrow", bus1.borrow_out, 33'(!a1 && b1));
         bus1.done_ready = 1'b1;
         @(posedge clk); #1;
         bus1.done_ready = 1'b0;
         check("w1_consumed", bus1.done_valid, 33'd0);
      end

      // Randomized operations with noise on start_valid/done_ready.
      for (int n = 0; n < 30; n++) begin
         case (n)
            0:       begin ra = 8'hFF; rb = 8'h00; end
            1:       begin ra = 8'h00; rb = 8'hFF; end
            2:       begin ra = 8'h80; rb = 8'h7F; end
            default: begin ra = 8'($urandom); rb = 8'($urandom); end
         endcase
         e = ref_sub(ra, rb);
         bus8.done_ready = 1'($urandom_range(0, 1));
         start8(ra, rb);
         wait_done8(1'b1);
         result8("rand", e);
         hold8($urandom_range(0, 3), e);
         consume8(e);
      end

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
